// File: rtl/updown_seq_pkg.sv
// updown_counter_sequencer shared types.
// Opcode and FSM state encodings.
package updown_seq_pkg;

  typedef enum logic [1:0] {
    OP_LOAD = 2'b00,
    OP_UP   = 2'b01,
    OP_DOWN = 2'b10,
    OP_NOP  = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_EXEC = 2'b01,
    S_DONE = 2'b10
  } state_t;

endpackage

// File: rtl/updown_counter_core.sv
// Modulo-2^WIDTH up/down counter datapath.
// Load takes priority over counting.
module updown_counter_core #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load_en,
  input  logic [WIDTH-1:0] load_val,
  input  logic             cnt_en,
  input  logic             up_down,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      q <= '0;
    end else if (load_en) begin
      q <= load_val;
    end else if (cnt_en) begin
      q <= up_down ? q + WIDTH'(1) : q - WIDTH'(1);
    end
  end

endmodule

// File: rtl/updown_counter_sequencer.sv
// Round-robin command arbiter and sequencer
// driving a shared up/down counter.
module updown_counter_sequencer
  import updown_seq_pkg::*;
#(
  parameter int N_REQ  = 4,
  parameter int WIDTH  = 3,
  parameter int STEP_W = 4,
  parameter int ID_W   = $clog2(N_REQ)
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [2*N_REQ-1:0]      req_op,
  input  logic [WIDTH*N_REQ-1:0]  req_value,
  input  logic [STEP_W*N_REQ-1:0] req_steps,
  input  logic                    pause,
  output logic [WIDTH-1:0]        cnt_q,
  output logic                    busy,
  output logic [ID_W-1:0]         owner_id,
  output logic                    done_valid,
  output logic [ID_W-1:0]         done_id
);

  state_t            state;
  op_t               op_q;
  logic [WIDTH-1:0]  val_q;
  logic [STEP_W-1:0] left_q;
  logic [ID_W-1:0]   rr_ptr;

  logic              win_ok;
  logic [ID_W-1:0]   win_id;
  op_t               win_op;
  logic [WIDTH-1:0]  win_val;
  logic [STEP_W-1:0] win_steps;
  int                idx;

  // Scan downward so the nearest requester at/after rr_ptr wins last.
  always_comb begin
    win_ok    = 1'b0;
    win_id    = '0;
    win_op    = OP_NOP;
    win_val   = '0;
    win_steps = '0;
    idx       = 0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = (int'(rr_ptr) + k) % N_REQ;
      if (req_valid[idx]) begin
        win_ok    = 1'b1;
        win_id    = ID_W'(idx);
        win_op    = op_t'(req_op[2*idx +: 2]);
        win_val   = req_value[WIDTH*idx +: WIDTH];
        win_steps = req_steps[STEP_W*idx +: STEP_W];
      end
    end
  end

  logic accept;

  always_comb begin
    req_ready = '0;
    if (reset_n && state == S_IDLE && !pause && win_ok)
      req_ready = N_REQ'(1) << win_id;
  end

  assign accept = |req_ready;

  logic run;
  logic is_step;
  logic load_en;
  logic cnt_en;
  logic last;

  assign run     = (state == S_EXEC) && !pause;
  assign is_step = (op_q == OP_UP) || (op_q == OP_DOWN);
  assign load_en = run && (op_q == OP_LOAD);
  assign cnt_en  = run && is_step && (left_q != '0);
  assign last    = !is_step || (left_q <= STEP_W'(1));

  updown_counter_core #(.WIDTH(WIDTH)) u_core (
    .clk      (clk),
    .reset_n  (reset_n),
    .load_en  (load_en),
    .load_val (val_q),
    .cnt_en   (cnt_en),
    .up_down  (op_q == OP_UP),
    .q        (cnt_q)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      op_q       <= OP_NOP;
      val_q      <= '0;
      left_q     <= '0;
      rr_ptr     <= '0;
      owner_id   <= '0;
      busy       <= 1'b0;
      done_valid <= 1'b0;
      done_id    <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (accept) begin
            state    <= S_EXEC;
            busy     <= 1'b1;
            owner_id <= win_id;
            op_q     <= win_op;
            val_q    <= win_val;
            left_q   <= win_steps;
            rr_ptr   <= (int'(win_id) == N_REQ - 1) ?
                        '0 : win_id + ID_W'(1);
          end
        end
        S_EXEC: begin
          if (run) begin
            if (cnt_en)
              left_q <= left_q - STEP_W'(1);
            if (last) begin
              state      <= S_DONE;
              done_valid <= 1'b1;
              done_id    <= owner_id;
            end
          end
        end
        S_DONE: begin
          state      <= S_IDLE;
          busy       <= 1'b0;
          done_valid <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_updown_counter_sequencer.sv
// Bench for updown_counter_sequencer: directed
// scenarios plus random traffic against a model.
module tb_updown_counter_sequencer;

  localparam int N  = 4;
  localparam int W  = 3;
  localparam int SW = 4;
  localparam int IW = 2;
  localparam int M  = 1 << W;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic            pause = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_ready;
  logic [2*N-1:0]  req_op;
  logic [W*N-1:0]  req_value;
  logic [SW*N-1:0] req_steps;
  logic [W-1:0]    cnt_q;
  logic            busy;
  logic [IW-1:0]   owner_id;
  logic            done_valid;
  logic [IW-1:0]   done_id;

  logic [1:0]    f_op    [N];
  logic [W-1:0]  f_val   [N];
  logic [SW-1:0] f_steps [N];

  always_comb begin
    req_op    = '0;
    req_value = '0;
    req_steps = '0;
    for (int i = 0; i < N; i++) begin
      req_op[2*i +: 2]     = f_op[i];
      req_value[W*i +: W]  = f_val[i];
      req_steps[SW*i +: SW] = f_steps[i];
    end
  end

  updown_counter_sequencer #(
    .N_REQ(N), .WIDTH(W), .STEP_W(SW), .ID_W(IW)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_value  (req_value),
    .req_steps  (req_steps),
    .pause      (pause),
    .cnt_q      (cnt_q),
    .busy       (busy),
    .owner_id   (owner_id),
    .done_valid (done_valid),
    .done_id    (done_id)
  );

  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;
  bit chk_en = 1'b0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(string name);
    compared++;
    mismatched++;
    $display("FAIL %s: no response within bound at %0t", name, $time);
  endtask

  // Behavioural model: 0 idle, 1 executing, 2 reporting completion.
  int m_cnt = 0, m_ptr = 0, m_phase = 0, m_owner = 0;
  int m_left = 0, m_op = 3, m_val = 0;
  logic [N-1:0] m_acc = '0;

  function automatic logic [N-1:0] exp_ready();
    if (!reset_n || m_phase != 0 || pause) return '0;
    for (int k = 0; k < N; k++)
      if (req_valid[(m_ptr + k) % N]) return N'(1) << ((m_ptr + k) % N);
    return '0;
  endfunction

  always @(posedge clk) begin
    logic [N-1:0] r;
    r = exp_ready();
    m_acc = '0;
    if (!reset_n) begin
      m_cnt = 0; m_ptr = 0; m_phase = 0; m_owner = 0;
    end else if (m_phase == 0) begin
      for (int i = 0; i < N; i++)
        if (r[i]) begin
          m_acc[i] = 1'b1;
          m_owner = i;
          m_op = f_op[i];
          m_val = f_val[i];
          m_left = f_steps[i];
          m_ptr = (i + 1) % N;
          m_phase = 1;
        end
    end else if (m_phase == 1) begin
      if (!pause) begin
        if (m_op == 0) begin
          m_cnt = m_val;
          m_phase = 2;
        end else if (m_op == 3 || m_left == 0) begin
          m_phase = 2;
        end else begin
          m_cnt = (m_op == 1) ? (m_cnt + 1) % M : (m_cnt + M - 1) % M;
          m_left--;
          if (m_left == 0) m_phase = 2;
        end
      end
    end else begin
      m_phase = 0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("req_ready", 32'(req_ready), 32'(exp_ready()));
      check("cnt_q", 32'(cnt_q), m_cnt);
      check("busy", 32'(busy), 32'(m_phase != 0));
      check("owner_id", 32'(owner_id), m_owner);
      check("done_valid", 32'(done_valid), 32'(m_phase == 2));
      if (m_phase == 2) check("done_id", 32'(done_id), m_owner);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cmd(int i, int op, int val, int st);
    f_op[i] = 2'(op);
    f_val[i] = W'(val);
    f_steps[i] = SW'(st);
    req_valid[i] = 1'b1;
  endtask

  task automatic grant_next(output int id);
    id = -1;
    for (int t = 0; t < 40; t++) begin
      #1;
      for (int k = 0; k < N; k++)
        if (req_ready[k]) id = k;
      if (id >= 0) begin
        tick();
        req_valid[id] = 1'b0;
        return;
      end
      tick();
    end
    timeout("grant");
  endtask

  task automatic cmd(int i, int op, int val, int st);
    int id;
    set_cmd(i, op, val, st);
    grant_next(id);
    if (id >= 0) check("cmd_grant_id", id, i);
  endtask

  task automatic wait_idle();
    for (int t = 0; t < 40; t++) begin
      if (!busy && !done_valid) return;
      tick();
    end
    timeout("wait_idle");
  endtask

  task automatic wait_done(output int id);
    id = -1;
    for (int t = 0; t < 40; t++) begin
      if (done_valid) begin
        id = done_id;
        return;
      end
      tick();
    end
    timeout("wait_done");
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
  endtask

  initial begin
    int id;
    for (int i = 0; i < N; i++) begin
      f_op[i] = 2'b11; f_val[i] = '0; f_steps[i] = '0;
    end
    tick();
    chk_en = 1'b1;
    tick();
    check("rst_cnt", 32'(cnt_q), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_ready", 32'(req_ready), 0);
    reset_n = 1'b1;

    // Load 5 from requester 0.
    set_cmd(0, 0, 5, 0);
    #1;
    check("load_ready", 32'(req_ready), 32'b0001);
    tick();
    req_valid[0] = 1'b0;
    check("load_busy", 32'(busy), 1);
    tick();
    check("load_cnt", 32'(cnt_q), 5);
    check("load_done", 32'(done_valid), 1);
    check("load_done_id", 32'(done_id), 0);
    tick();
    check("load_idle", 32'(busy), 0);

    // Up by 3 from 6 wraps to 1, then down by 2.
    cmd(1, 0, 6, 0);
    wait_idle();
    cmd(1, 1, 0, 3);
    tick(); check("up_s1", 32'(cnt_q), 7);
    tick(); check("up_s2", 32'(cnt_q), 0);
    tick(); check("up_s3", 32'(cnt_q), 1);
    check("up_done", 32'(done_valid), 1);
    check("up_done_id", 32'(done_id), 1);
    wait_idle();
    cmd(1, 2, 0, 2);
    tick(); check("dn_s1", 32'(cnt_q), 0);
    tick(); check("dn_s2", 32'(cnt_q), 7);
    wait_idle();

    // Round-robin with all four requesters loading their own index.
    do_reset();
    for (int i = 0; i < N; i++) set_cmd(i, 0, i, 0);
    for (int g = 0; g < N; g++) begin
      grant_next(id);
      check("rr_grant", id, g);
      wait_done(id);
      check("rr_done_id", id, g);
    end
    wait_idle();
    check("rr_cnt", 32'(cnt_q), 3);
    set_cmd(2, 0, 2, 0);
    set_cmd(0, 0, 0, 0);
    grant_next(id);
    check("rr2_first", id, 0);
    grant_next(id);
    check("rr2_second", id, 2);
    wait_idle();

    // Pause for two cycles after the second step.
    do_reset();
    cmd(0, 1, 0, 4);
    tick(); check("p_s1", 32'(cnt_q), 1);
    tick(); check("p_s2", 32'(cnt_q), 2);
    pause = 1'b1;
    tick(); check("p_h1", 32'(cnt_q), 2);
    tick(); check("p_h2", 32'(cnt_q), 2);
    check("p_hold_done", 32'(done_valid), 0);
    pause = 1'b0;
    tick(); check("p_s3", 32'(cnt_q), 3);
    tick(); check("p_s4", 32'(cnt_q), 4);
    check("p_done", 32'(done_valid), 1);
    wait_idle();
    pause = 1'b1;
    set_cmd(1, 0, 1, 0);
    #1;
    check("p_idle_ready", 32'(req_ready), 0);
    tick();
    check("p_idle_busy", 32'(busy), 0);
    pause = 1'b0;
    grant_next(id);
    check("p_after_grant", id, 1);
    wait_idle();
    check("p_after_cnt", 32'(cnt_q), 1);

    // Zero-step UP and NOP each take one EXEC cycle.
    cmd(2, 1, 0, 0);
    tick();
    check("z_done", 32'(done_valid), 1);
    check("z_cnt", 32'(cnt_q), 1);
    wait_idle();
    cmd(3, 3, 6, 7);
    tick();
    check("nop_done", 32'(done_valid), 1);
    check("nop_id", 32'(done_id), 3);
    check("nop_cnt", 32'(cnt_q), 1);
    wait_idle();

    // Reset in the middle of a 5-step UP.
    cmd(2, 1, 0, 5);
    tick(); tick();
    check("mid_cnt", 32'(cnt_q), 3);
    reset_n = 1'b0;
    set_cmd(1, 0, 4, 0);
    set_cmd(0, 0, 6, 0);
    #1;
    check("mid_rst_ready", 32'(req_ready), 0);
    tick();
    check("mid_rst_cnt", 32'(cnt_q), 0);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_done", 32'(done_valid), 0);
    reset_n = 1'b1;
    grant_next(id);
    check("mid_first", id, 0);
    grant_next(id);
    check("mid_second", id, 1);
    wait_idle();

    // Random traffic checked every cycle by the model.
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < N; i++)
        if (m_acc[i]) req_valid[i] = 1'b0;
      for (int i = 0; i < N; i++)
        if (!req_valid[i] && $urandom_range(0, 3) == 0)
          set_cmd(i, int'($urandom_range(0, 3)), int'($urandom_range(0, M - 1)),
                  ($urandom_range(0, 9) == 0) ? 15 : int'($urandom_range(0, 5)));
      pause = ($urandom_range(0, 9) == 0);
      reset_n = ($urandom_range(0, 299) != 0);
      tick();
    end
    reset_n = 1'b1;
    pause = 1'b0;
    req_valid = '0;
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
